// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and sync polarities for the VGA output path.
// Renderers and the VGA wrapper import these so every stage agrees on the frame geometry.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic HS_POL = 1'b0;
  localparam logic VS_POL = 1'b0;

  // Bits needed to hold 0..total-1.
  function automatic int cnt_bits(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of depth D with a per-bit reset value.
// D=0 collapses to a plain wire.
module vga_delay_line #(
  parameter int             W       = 1,
  parameter int             D       = 0,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         csi_clk50,
  input  logic         csi_reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (D == 0) begin : g_wire
      logic wire_unused;
      assign wire_unused = ^{csi_clk50, csi_reset, en};
      assign dout        = din;
    end else begin : g_pipe
      logic [W-1:0] stage_reg [D];

      always_ff @(posedge csi_clk50 or posedge csi_reset) begin
        if (csi_reset) begin
          for (int i = 0; i < D; i++) stage_reg[i] <= RST_VAL;
        end else if (en) begin
          stage_reg[0] <= din;
          for (int i = 1; i < D; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[D-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: pixel strobe at half the system clock, h/v counters,
// blanking decode, and sync/data-enable delayed to match the renderer's RGB pipeline.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int   H_FP       = vga_pkg::H_FP,
  parameter int   H_SYNC     = vga_pkg::H_SYNC,
  parameter int   H_BP       = vga_pkg::H_BP,
  parameter int   V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int   V_FP       = vga_pkg::V_FP,
  parameter int   V_SYNC     = vga_pkg::V_SYNC,
  parameter int   V_BP       = vga_pkg::V_BP,
  parameter logic HS_POL     = vga_pkg::HS_POL,
  parameter logic VS_POL     = vga_pkg::VS_POL,
  parameter int   SYNC_DELAY = 2,
  parameter int   X_BITS     = 10,
  parameter int   Y_BITS     = 10
) (
  input  logic              csi_clk50,
  input  logic              csi_reset,
  output logic              coe_pix_en,
  output logic [X_BITS-1:0] coe_x,
  output logic [Y_BITS-1:0] coe_y,
  output logic              coe_active,
  output logic              coe_line_start,
  output logic              coe_frame_start,
  output logic              coe_hsync,
  output logic              coe_vsync,
  output logic              coe_de
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = cnt_bits(H_TOT);
  localparam int VW    = cnt_bits(V_TOT);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic          pix_en_reg;
  logic [HW-1:0] hc_reg, hc_next;
  logic [VW-1:0] vc_reg, vc_next;
  logic          act;
  sync_t         raw_sync, dly_sync;

  always_ff @(posedge csi_clk50 or posedge csi_reset) begin
    if (csi_reset) begin
      pix_en_reg <= 1'b0;
      hc_reg     <= '0;
      vc_reg     <= '0;
    end else begin
      pix_en_reg <= ~pix_en_reg;
      hc_reg     <= hc_next;
      vc_reg     <= vc_next;
    end
  end

  always_comb begin
    hc_next = hc_reg;
    vc_next = vc_reg;
    if (pix_en_reg) begin
      if (hc_reg == H_LAST) begin
        hc_next = '0;
        vc_next = (vc_reg == V_LAST) ? '0 : vc_reg + 1'b1;
      end else begin
        hc_next = hc_reg + 1'b1;
      end
    end
  end

  assign act = (hc_reg < H_ACT_C) && (vc_reg < V_ACT_C);

  always_comb begin
    raw_sync    = '0;
    raw_sync.hs = (hc_reg >= H_SS && hc_reg <= H_SE) ? HS_POL : ~HS_POL;
    raw_sync.vs = (vc_reg >= V_SS && vc_reg <= V_SE) ? VS_POL : ~VS_POL;
    raw_sync.de = act;
  end

  // Stages advance once per pixel slot so the lag is SYNC_DELAY pixels, not clocks.
  vga_delay_line #(
    .W       (3),
    .D       (SYNC_DELAY),
    .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
  ) u_delay (
    .csi_clk50 (csi_clk50),
    .csi_reset (csi_reset),
    .en        (pix_en_reg),
    .din       (raw_sync),
    .dout      (dly_sync)
  );

  assign coe_pix_en      = pix_en_reg;
  assign coe_x           = X_BITS'(hc_reg);
  assign coe_y           = Y_BITS'(vc_reg);
  assign coe_active      = act;
  assign coe_line_start  = pix_en_reg && (hc_reg == '0) && (vc_reg < V_ACT_C);
  assign coe_frame_start = pix_en_reg && (hc_reg == '0) && (vc_reg == '0);
  assign coe_hsync       = dly_sync.hs;
  assign coe_vsync       = dly_sync.vs;
  assign coe_de          = dly_sync.de;

endmodule
